axil_reg_bridge: RTL
====================

Name: axil_reg_bridge

Overview:
- AXI4-Lite slave to internal register-bus master bridge.
- Sits directly upstream of the register mux and drives its m0_* master port.
- Converts AXI4-Lite AW/W/B and AR/R channel handshakes into held-request/ready register-bus transfers.
- Write and read paths are independent and may be in flight concurrently; a timeout terminates a transfer the register bus never completes.

Parameters:
TIMEOUT, 256, cycles a reg-bus request may wait for ready before it terminates with SLVERR; 0 disables the timeout
TO_WIDTH, 9, width of each timeout counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
s_axi_awvalid  in  1  AXI write address valid
s_axi_awready  out  1  AXI write address ready
s_axi_awaddr  in  32  AXI write address
s_axi_wvalid  in  1  AXI write data valid
s_axi_wready  out  1  AXI write data ready
s_axi_wdata  in  32  AXI write data
s_axi_wstrb  in  4  AXI byte strobes
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_araddr  in  32  read address
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
m0_wen  out  1  reg-bus write request
m0_waddr  out  32  reg-bus write address
m0_wdata  out  32  reg-bus write data
m0_wstrb  out  8  reg-bus strobes; {4'b0, captured wstrb}
m0_wrdy  in  1  reg-bus write ready
m0_ren  out  1  reg-bus read request
m0_raddr  out  32  reg-bus read address
m0_rdata  in  32  reg-bus read data
m0_rrdy  in  1  reg-bus read ready

Behaviour:
Reset and outputs:
- Asynchronous active-low reset on resetn, deasserted synchronously by design.
- Reset values: all outputs 0, except awready/wready/arready = 1.
- Both FSMs reset to IDLE.
- Reset mid-transfer drops the transfer immediately; no response is issued.
- All outputs are registered.

Reg-bus rule:
- The request (wen or ren) and its addr/data/strb stay high and stable until ready is sampled 1 on a rising edge.
- The transfer completes on that edge; rdata is valid in that same cycle.

Write FSM (W_IDLE, W_REQ, W_RESP):
- W_IDLE: awready = ~aw_held, wready = ~w_held.
- AW and W are captured independently on their handshakes, in any order or in the same cycle.
- Once both are held (including the capturing edge), move to W_REQ next cycle: m0_wen = 1, awready = wready = 0, timeout counter cleared.
- W_REQ with m0_wrdy = 1: bresp = 00, go to W_RESP.
- W_REQ with counter reaching TIMEOUT-1 and no wrdy: drop wen, bresp = 10, go to W_RESP.
- W_RESP: bvalid = 1 until bready. On the bready edge, clear the held flags and return to W_IDLE with awready = wready = 1.
- Minimum latency: AW+W accepted on edge N, m0_wen high in cycle N+1, wrdy sampled at N+1 end, bvalid high in cycle N+2.

Read FSM (R_IDLE, R_REQ, R_RESP):
- R_IDLE: arready = 1. An AR handshake captures araddr; next state R_REQ with m0_ren = 1 and arready = 0.
- R_REQ with m0_rrdy = 1: capture m0_rdata into rdata, rresp = 00, go to R_RESP.
- R_REQ on timeout: rdata = 0, rresp = 10, go to R_RESP.
- R_RESP: rvalid = 1, rdata stable until rready; then back to R_IDLE.
- Minimum latency: AR on edge N, ren in N+1, rvalid in N+2.

Boundaries:
- A second AW or W arriving while its buffer is held is back-pressured (ready = 0).
- Concurrent read and write proceed independently with no ordering between them.
- wrdy or rrdy asserted while no request is active is ignored.
- Addresses pass through unmodified, full 32 bits.
- With TIMEOUT = 0 the bridge waits indefinitely.
- Timeout counters saturate and reset on every new request.

Test Plan:
1. AW(0x804) and W(0xA5A5_0001, strb 0xF) in the same cycle, wrdy tied 1 -> m0_wen one cycle with waddr 0x804, wstrb 0x0F; bvalid 2 cycles after accept, bresp 00.
2. W sent 3 cycles before AW, bready held 0 for 4 cycles -> single m0_wen pulse; bvalid held stable; awready/wready stay 0 until the bready edge.
3. AR 0x10, rrdy asserted 5 cycles after ren with rdata 0x1234_5678 -> ren held exactly 5 cycles then drops; rvalid with rdata 0x1234_5678, rresp 00.
4. TIMEOUT=8, rrdy never asserted -> ren drops after 8 cycles; rvalid with rdata 0, rresp 10. Repeat on the write path -> bresp 10.
5. Concurrent write and read issued in the same cycle with different ready delays -> both complete correctly, no cross-corruption.
6. resetn pulsed low while in W_REQ and R_REQ -> m0_wen/m0_ren drop asynchronously; no bvalid/rvalid after release; next transaction works normally.

Source files
------------

// File: rtl/axil_reg_bridge_if.sv
// Signal bundle around axil_reg_bridge: AXI4-Lite on one side, held-request register bus on the other.
// The slave modport is the bridge's view; the master modport is the surrounding system's view.
interface axil_reg_bridge_if;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        m0_wen;
    logic [31:0] m0_waddr;
    logic [31:0] m0_wdata;
    logic [7:0]  m0_wstrb;
    logic        m0_wrdy;
    logic        m0_ren;
    logic [31:0] m0_raddr;
    logic [31:0] m0_rdata;
    logic        m0_rrdy;

    modport slave (
        input  s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
               s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
               m0_wrdy, m0_rdata, m0_rrdy,
        output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
               s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp,
               m0_wen, m0_waddr, m0_wdata, m0_wstrb, m0_ren, m0_raddr
    );

    modport master (
        output s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
               s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_rready,
               m0_wrdy, m0_rdata, m0_rrdy,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
               s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp,
               m0_wen, m0_waddr, m0_wdata, m0_wstrb, m0_ren, m0_raddr
    );
endinterface

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave to register-bus master bridge with independent write/read FSMs,
// fully registered outputs and an optional per-request timeout that answers SLVERR.
module axil_reg_bridge #(
    parameter int unsigned TIMEOUT  = 256,
    parameter int unsigned TO_WIDTH = 9
) (
    input  logic              clk,
    input  logic              resetn,
    axil_reg_bridge_if.slave  bus
);
    localparam logic [1:0]          RESP_OKAY   = 2'b00;
    localparam logic [1:0]          RESP_SLVERR = 2'b10;
    localparam bit                  TO_EN       = (TIMEOUT != 0);
    localparam logic [TO_WIDTH-1:0] TO_LAST     = TO_WIDTH'(TO_EN ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} r_state_t;

    w_state_t            w_state, w_next;
    r_state_t            r_state, r_next;
    logic                aw_held, w_held, aw_held_next, w_held_next;
    logic                aw_hs, w_hs, ar_hs;
    logic                w_timeout, r_timeout;
    logic [TO_WIDTH-1:0] w_cnt, r_cnt;

    // Readies are only ever high in the idle states, so these cannot fire mid-transfer.
    assign aw_hs     = bus.s_axi_awvalid & bus.s_axi_awready;
    assign w_hs      = bus.s_axi_wvalid  & bus.s_axi_wready;
    assign ar_hs     = bus.s_axi_arvalid & bus.s_axi_arready;
    assign w_timeout = TO_EN && (w_cnt == TO_LAST) && !bus.m0_wrdy;
    assign r_timeout = TO_EN && (r_cnt == TO_LAST) && !bus.m0_rrdy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next       = w_state;
        aw_held_next = aw_held;
        w_held_next  = w_held;
        case (w_state)
            W_IDLE: begin
                aw_held_next = aw_held | aw_hs;
                w_held_next  = w_held | w_hs;
                if (aw_held_next && w_held_next) w_next = W_REQ;
            end
            W_REQ: begin
                if (bus.m0_wrdy || w_timeout) w_next = W_RESP;
            end
            W_RESP: begin
                if (bus.s_axi_bready) begin
                    w_next       = W_IDLE;
                    aw_held_next = 1'b0;
                    w_held_next  = 1'b0;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (ar_hs) r_next = R_REQ;
            R_REQ:  if (bus.m0_rrdy || r_timeout) r_next = R_RESP;
            R_RESP: if (bus.s_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Write-side registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_held           <= 1'b0;
            w_held            <= 1'b0;
            bus.s_axi_awready <= 1'b1;
            bus.s_axi_wready  <= 1'b1;
            bus.s_axi_bvalid  <= 1'b0;
            bus.s_axi_bresp   <= RESP_OKAY;
            bus.m0_wen        <= 1'b0;
            bus.m0_waddr      <= '0;
            bus.m0_wdata      <= '0;
            bus.m0_wstrb      <= '0;
            w_cnt             <= '0;
        end else begin
            aw_held           <= aw_held_next;
            w_held            <= w_held_next;
            bus.s_axi_awready <= (w_next == W_IDLE) && !aw_held_next;
            bus.s_axi_wready  <= (w_next == W_IDLE) && !w_held_next;
            bus.m0_wen        <= (w_next == W_REQ);
            bus.s_axi_bvalid  <= (w_next == W_RESP);
            if (aw_hs) bus.m0_waddr <= bus.s_axi_awaddr;
            if (w_hs) begin
                bus.m0_wdata <= bus.s_axi_wdata;
                bus.m0_wstrb <= {4'b0000, bus.s_axi_wstrb};
            end
            if (w_state == W_REQ && w_next == W_RESP)
                bus.s_axi_bresp <= bus.m0_wrdy ? RESP_OKAY : RESP_SLVERR;
            if (w_state != W_REQ)      w_cnt <= '0;
            else if (w_cnt != TO_LAST) w_cnt <= w_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.s_axi_arready <= 1'b1;
            bus.s_axi_rvalid  <= 1'b0;
            bus.s_axi_rdata   <= '0;
            bus.s_axi_rresp   <= RESP_OKAY;
            bus.m0_ren        <= 1'b0;
            bus.m0_raddr      <= '0;
            r_cnt             <= '0;
        end else begin
            bus.s_axi_arready <= (r_next == R_IDLE);
            bus.m0_ren        <= (r_next == R_REQ);
            bus.s_axi_rvalid  <= (r_next == R_RESP);
            if (ar_hs) bus.m0_raddr <= bus.s_axi_araddr;
            if (r_state == R_REQ && r_next == R_RESP) begin
                bus.s_axi_rdata <= bus.m0_rrdy ? bus.m0_rdata : 32'h0;
                bus.s_axi_rresp <= bus.m0_rrdy ? RESP_OKAY : RESP_SLVERR;
            end
            if (r_state != R_REQ)      r_cnt <= '0;
            else if (r_cnt != TO_LAST) r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
